// File: rtl/svm_dma_ctrl.sv
// Single-word DMA controller: queues read/write requests, issues them to the data SRAM
// under an arbiter grant and returns read data in issue order with fixed latency.
module svm_dma_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2,
  parameter int SRAM_AW    = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_dma_req_vld,
  output logic               mem_dma_rdy,
  input  logic               mem_dma_rdbar_wr,
  input  logic [31:0]        mem_dma_req_addr,
  input  logic [31:0]        mem_dma_req_data,
  output logic [31:0]        mem_dma_rd_data,
  output logic               mem_dma_rd_data_vld,
  output logic               sram_req,
  input  logic               sram_gnt,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  input  logic               flush,
  input  logic               err_clr,
  output logic               err_addr,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // state_dbg encoding: 0 = IDLE, 1 = ISSUE, 2 = FLUSH
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;
  logic              full_q;
  logic              fifo_wr   [FIFO_DEPTH];
  logic [31:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic              head_wr, head_legal;
  logic [31:0]       head_addr, head_data;
  logic              push, pop, clear, flush_now;
  logic              rd_issue, rd_zero, err_set;
  logic [RD_LAT:0]   pipe_vld;
  logic [RD_LAT-1:0] pipe_zero;

  assign head_wr    = fifo_wr[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign head_legal = (head_addr[1:0] == 2'b00) && ((head_addr >> (SRAM_AW + 2)) == 32'd0);

  // Request handshake: a request is taken on a cycle with mem_dma_req_vld && mem_dma_rdy,
  // unless flush is seen in that same cycle, in which case the request is dropped.
  assign mem_dma_rdy = !full_q && (state != FLUSH);
  assign flush_now   = flush && (state != FLUSH);
  assign push        = mem_dma_req_vld && mem_dma_rdy && !flush;
  assign clear       = flush_now || (state == FLUSH);

  assign sram_we             = sram_req && head_wr;
  assign sram_addr           = sram_req ? head_addr[SRAM_AW+1:2] : '0;
  assign sram_wdata          = sram_req ? head_data : '0;
  assign mem_dma_rd_data_vld = pipe_vld[RD_LAT];
  assign busy                = (count != '0) || (|pipe_vld);
  assign state_dbg           = state;

  always_comb begin
    state_next = state;
    sram_req   = 1'b0;
    pop        = 1'b0;
    rd_issue   = 1'b0;
    rd_zero    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (flush) state_next = FLUSH;
        else if (count != '0) state_next = ISSUE;
      end
      ISSUE: begin
        if (flush) begin
          state_next = FLUSH;
        end else if (count == '0) begin
          state_next = IDLE;
        end else begin
          if (head_legal) begin
            sram_req = 1'b1;
            pop      = sram_gnt;
            rd_issue = sram_gnt && !head_wr;
          end else begin
            // Bad address: drop the entry without touching the SRAM; reads still return zero.
            pop      = 1'b1;
            rd_issue = !head_wr;
            rd_zero  = 1'b1;
            err_set  = 1'b1;
          end
          if (pop && !push && (count == CW'(1))) state_next = IDLE;
        end
      end
      FLUSH: begin
        if (pipe_vld == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (clear) count_next = '0;
    else count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      full_q          <= 1'b0;
      pipe_vld        <= '0;
      pipe_zero       <= '0;
      mem_dma_rd_data <= '0;
      err_addr        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_wr[i]   <= 1'b0;
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      state  <= state_next;
      count  <= count_next;
      full_q <= (count_next == CW'(FIFO_DEPTH));
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_wr[wr_ptr]   <= mem_dma_rdbar_wr;
          fifo_addr[wr_ptr] <= mem_dma_req_addr;
          fifo_data[wr_ptr] <= mem_dma_req_data;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
      // Reads already handed to the SRAM keep flowing through a flush.
      pipe_vld     <= {pipe_vld[RD_LAT-1:0], rd_issue};
      pipe_zero[0] <= rd_issue && rd_zero;
      for (int i = 1; i < RD_LAT; i++) pipe_zero[i] <= pipe_zero[i-1];
      if (pipe_vld[RD_LAT-1]) mem_dma_rd_data <= pipe_zero[RD_LAT-1] ? 32'h0 : sram_rdata;
      if (err_set) err_addr <= 1'b1;
      else if (err_clr) err_addr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svm_dma_ctrl.sv
// Bench for svm_dma_ctrl: SRAM model, directed vector table, hand-written corner
// sequences and a randomized run against a request-level reference model.
module tb_svm_dma_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 2;
  localparam int SRAM_AW    = 14;
  localparam int SRAM_WORDS = 1 << SRAM_AW;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mem_dma_req_vld = 1'b0;
  logic               mem_dma_rdy;
  logic               mem_dma_rdbar_wr = 1'b0;
  logic [31:0]        mem_dma_req_addr = '0;
  logic [31:0]        mem_dma_req_data = '0;
  logic [31:0]        mem_dma_rd_data;
  logic               mem_dma_rd_data_vld;
  logic               sram_req;
  logic               sram_gnt = 1'b0;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic               flush = 1'b0;
  logic               err_clr = 1'b0;
  logic               err_addr;
  logic               busy;
  logic [1:0]         state_dbg;

  svm_dma_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .mem_dma_req_vld(mem_dma_req_vld), .mem_dma_rdy(mem_dma_rdy),
    .mem_dma_rdbar_wr(mem_dma_rdbar_wr), .mem_dma_req_addr(mem_dma_req_addr),
    .mem_dma_req_data(mem_dma_req_data), .mem_dma_rd_data(mem_dma_rd_data),
    .mem_dma_rd_data_vld(mem_dma_rd_data_vld), .sram_req(sram_req), .sram_gnt(sram_gnt),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .flush(flush), .err_clr(err_clr), .err_addr(err_addr),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [SRAM_WORDS];
  logic [31:0] rd_pipe  [RD_LAT];
  assign sram_rdata = rd_pipe[RD_LAT-1];

  function automatic logic [31:0] def_word(input int w);
    return 32'hC0DE_0000 ^ 32'(w);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SRAM_WORDS; i++) sram_mem[i] <= def_word(i);
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (sram_req && sram_gnt && sram_we) sram_mem[sram_addr] <= sram_wdata;
      rd_pipe[0] <= (sram_req && sram_gnt && !sram_we) ? sram_mem[sram_addr] : 32'h0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int];
  logic        err_exp = 1'b0;
  bit          sb_en = 1'b0;

  int                 rd_cnt = 0, acc_cnt = 0;
  int                 last_vld_cyc = 0, last_acc_cyc = 0;
  int                 acc_cyc_q[$], vld_cyc_q[$];
  logic [31:0]        last_rd = '0, last_acc_wdata = '0;
  logic [SRAM_AW-1:0] last_acc_addr = '0;
  logic               last_acc_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < (32'd4 << SRAM_AW));
  endfunction

  // Request-level model: requests complete in acceptance order.
  task automatic model_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int w;
    w = int'(addr >> 2);
    if (!legal(addr)) begin
      err_exp = 1'b1;
      if (!wr) exp_q.push_back(32'h0);
    end else if (wr) begin
      ref_mem[w] = data;
    end else begin
      exp_q.push_back(ref_mem.exists(w) ? ref_mem[w] : def_word(w));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (sram_req && sram_gnt) begin
      acc_cnt++;
      last_acc_cyc   = cyc;
      last_acc_addr  = sram_addr;
      last_acc_we    = sram_we;
      last_acc_wdata = sram_wdata;
      acc_cyc_q.push_back(cyc);
    end
    if (mem_dma_rd_data_vld) begin
      rd_cnt++;
      last_rd      = mem_dma_rd_data;
      last_vld_cyc = cyc;
      vld_cyc_q.push_back(cyc);
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got read 0x%08h, expected no return", mem_dma_rd_data);
        end else begin
          check("sb_rd_data", mem_dma_rd_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    mem_dma_req_vld = 1'b0;
    sram_gnt = 1'b0;
    flush = 1'b0;
    err_clr = 1'b0;
    ref_mem.delete();
    exp_q.delete();
    err_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    mem_dma_req_vld  = 1'b1;
    mem_dma_rdbar_wr = wr;
    mem_dma_req_addr = addr;
    mem_dma_req_data = data;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = mem_dma_rdy && !flush;
      @(posedge clk);
      #1;
    end
    mem_dma_req_vld = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got no accept for addr 0x%08h, expected accept", addr);
    end else if (sb_en) begin
      model_req(wr, addr, data);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle_timeout: got busy=1, expected busy=0", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic               wr;
    logic [31:0]        addr;
    logic [31:0]        data;
    int                 exp_acc;
    logic [SRAM_AW-1:0] exp_saddr;
    logic               exp_err;
    logic [31:0]        exp_rdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int a0, r0, span;
    logic        wr;
    logic [31:0] addr;

    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hA5A5_0001, 1, 14'h0040, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         1, 14'h0040, 1'b0, 32'hA5A5_0001};
    vecs[2]  = '{1'b0, 32'h0000_0102, 32'h0,         0, 14'h0000, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0001_0000, 32'h1111_2222, 0, 14'h0000, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_FFFC, 32'h0,         1, 14'h3FFF, 1'b0, 32'hC0DE_3FFF};
    vecs[5]  = '{1'b1, 32'h0000_FFFC, 32'h1234_5678, 1, 14'h3FFF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_FFFC, 32'h0,         1, 14'h3FFF, 1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b0, 32'h0000_0001, 32'h0,         0, 14'h0000, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         0, 14'h0000, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1, 14'h0000, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         1, 14'h0000, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 32'h0001_0000, 32'h0,         0, 14'h0000, 1'b1, 32'h0};

    // reset state
    do_reset();
    check("rst_rdy", mem_dma_rdy, 1);
    check("rst_vld", mem_dma_rd_data_vld, 0);
    check("rst_rd_data", mem_dma_rd_data, 0);
    check("rst_sram_req", sram_req, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_err", err_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);

    // table: one request at a time with grant held high
    for (int i = 0; i < 12; i++) begin
      pulse_err_clr();
      check($sformatf("v%0d_err_clr", i), err_addr, 0);
      sram_gnt = 1'b1;
      a0 = acc_cnt;
      r0 = rd_cnt;
      push_req(vecs[i].wr, vecs[i].addr, vecs[i].data);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_acc", i), acc_cnt - a0, vecs[i].exp_acc);
      if (vecs[i].exp_acc != 0) begin
        check($sformatf("v%0d_sram_addr", i), last_acc_addr, vecs[i].exp_saddr);
        check($sformatf("v%0d_sram_we", i), last_acc_we, vecs[i].wr);
        if (vecs[i].wr) check($sformatf("v%0d_sram_wdata", i), last_acc_wdata, vecs[i].data);
      end
      check($sformatf("v%0d_err", i), err_addr, vecs[i].exp_err);
      if (!vecs[i].wr) begin
        check($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, 1);
        check($sformatf("v%0d_rd_data", i), last_rd, vecs[i].exp_rdata);
        if (vecs[i].exp_acc != 0)
          check($sformatf("v%0d_latency", i), last_vld_cyc - last_acc_cyc, RD_LAT + 1);
      end
    end

    // error set and err_clr in the same cycle: error stays
    pulse_err_clr();
    push_req(1'b0, 32'h0000_0002, 32'h0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_wins", err_addr, 1);
    wait_idle("err_wins");
    pulse_err_clr();
    check("err_cleared", err_addr, 0);

    // five reads against a stalled grant, then back-to-back issue
    sb_en = 1'b1;
    sram_gnt = 1'b0;
    acc_cyc_q.delete();
    vld_cyc_q.delete();
    a0 = acc_cnt;
    r0 = rd_cnt;
    for (int i = 0; i < 4; i++) push_req(1'b0, 32'h200 + 32'(4 * i), 32'h0);
    @(negedge clk);
    check("t2_rdy_full", mem_dma_rdy, 0);
    check("t2_req_pending", sram_req, 1);
    check("t2_no_acc", acc_cnt - a0, 0);
    @(posedge clk); #1 sram_gnt = 1'b1;
    push_req(1'b0, 32'h210, 32'h0);
    wait_idle("t2");
    check("t2_acc", acc_cnt - a0, 5);
    span = (acc_cyc_q.size() == 5) ? acc_cyc_q[4] - acc_cyc_q[0] : -1;
    check("t2_acc_span", span, 4);
    check("t2_rd_cnt", rd_cnt - r0, 5);
    span = (vld_cyc_q.size() == 5) ? vld_cyc_q[4] - vld_cyc_q[0] : -1;
    check("t2_vld_span", span, 4);
    check("t2_exp_empty", exp_q.size(), 0);
    sb_en = 1'b0;

    // flush with three reads queued and one granted
    sram_gnt = 1'b0;
    a0 = acc_cnt;
    r0 = rd_cnt;
    for (int i = 0; i < 3; i++) push_req(1'b0, 32'h300 + 32'(4 * i), 32'h0);
    sram_gnt = 1'b1;
    @(posedge clk); #1;
    sram_gnt = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t4_req_on_flush", sram_req, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("t4_rdy_in_flush", mem_dma_rdy, 0);
    check("t4_state_flush", state_dbg, 2);
    wait_idle("t4");
    repeat (4) @(posedge clk);
    #1;
    check("t4_acc", acc_cnt - a0, 1);
    check("t4_rd_cnt", rd_cnt - r0, 1);
    check("t4_busy", busy, 0);
    check("t4_state_idle", state_dbg, 0);
    check("t4_rdy_after", mem_dma_rdy, 1);

    // asynchronous reset with two reads in flight
    sram_gnt = 1'b1;
    a0 = acc_cnt;
    push_req(1'b0, 32'h400, 32'h0);
    push_req(1'b0, 32'h404, 32'h0);
    for (int i = 0; i < 20 && (acc_cnt - a0) < 2; i++) @(negedge clk);
    check("t5_two_issued", acc_cnt - a0, 2);
    @(posedge clk); #2;
    r0 = rd_cnt;
    rst = 1'b1;
    ref_mem.delete();
    exp_q.delete();
    err_exp = 1'b0;
    #1;
    check("t5_rdy", mem_dma_rdy, 1);
    check("t5_vld", mem_dma_rd_data_vld, 0);
    check("t5_rd_data", mem_dma_rd_data, 0);
    check("t5_sram_req", sram_req, 0);
    check("t5_err", err_addr, 0);
    check("t5_busy", busy, 0);
    check("t5_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_return", rd_cnt - r0, 0);

    // randomized mixed traffic with a toggling grant
    sb_en = 1'b1;
    begin
      bit rand_done;
      rand_done = 1'b0;
      fork
        begin
          for (int n = 0; n < 200; n++) begin
            int w;
            w    = $urandom_range(0, 31);
            wr   = 1'($urandom_range(0, 1));
            addr = 32'h800 + 32'(4 * w);
            if ($urandom_range(0, 15) == 0)
              addr = ($urandom_range(0, 1) == 1) ? (addr | 32'($urandom_range(1, 3)))
                                                 : (32'h0001_0000 + 32'(4 * w));
            push_req(wr, addr, $urandom);
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
          end
          rand_done = 1'b1;
        end
        begin
          while (!rand_done) begin
            @(posedge clk);
            #1 sram_gnt = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    sram_gnt = 1'b1;
    wait_idle("t6");
    check("t6_exp_empty", exp_q.size(), 0);
    check("t6_err", err_addr, err_exp);
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
